// File: rtl/mul_seq_2bit_ctrl.sv
// ---------------------------------------------------------------------------
// mul_full_2bit
//   Purely combinational 2x2 unsigned multiplier. It is built from the four
//   partial-product bits and a half-adder chain rather than a '*' operator,
//   so it maps directly onto a handful of gates.
//
//   Ports:
//     a_i [1:0]  multiplicand digit
//     b_i [1:0]  multiplier digit
//     p_o [3:0]  product a_i * b_i
// ---------------------------------------------------------------------------
module mul_full_2bit (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);

    logic pp00;
    logic pp01;
    logic pp10;
    logic pp11;
    logic carry1;

    // Partial products. Two half adders combine them: the first adds the two
    // middle-weight bits, and the second adds that carry into the top bit.
    always_comb begin
        pp00   = a_i[0] & b_i[0];
        pp01   = a_i[0] & b_i[1];
        pp10   = a_i[1] & b_i[0];
        pp11   = a_i[1] & b_i[1];
        carry1 = pp10 & pp01;
        p_o    = {pp11 & carry1, pp11 ^ carry1, pp10 ^ pp01, pp00};
    end

endmodule

// ---------------------------------------------------------------------------
// mul_seq_2bit_ctrl
//   Sequential unsigned WIDTH x WIDTH multiplier. Each operand is split into
//   D = WIDTH/2 two-bit digits. One digit pair per cycle goes through a single
//   shared mul_full_2bit. Each 4-bit partial product is shifted into place and
//   added to a 2*WIDTH-bit accumulator. A RUN phase always lasts exactly D*D
//   cycles. WIDTH must be even and at least 2.
//
//   Ports:
//     clk        clock, all state changes on the rising edge
//     rst        synchronous active-high reset
//     in_valid   operands A/B are valid
//     in_ready   block can accept operands (IDLE and not in reset)
//     A, B       unsigned operands, WIDTH bits
//     out_valid  P holds a completed product
//     out_ready  consumer accepts P
//     P          product, 2*WIDTH bits, holds its value after the handshake
//     busy       high while a product is being formed or waiting to be taken
// ---------------------------------------------------------------------------
module mul_seq_2bit_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy
);

    localparam int D    = WIDTH / 2;
    localparam int ACCW = 2 * WIDTH;
    localparam int CW   = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic [ACCW-1:0]   p_q, p_d;
    logic [CW-1:0]     i_q, i_d;
    logic [CW-1:0]     j_q, j_d;

    logic [1:0]        digitA;
    logic [1:0]        digitB;
    logic [3:0]        p4;
    logic [CW:0]       digitSum;
    logic [ACCW-1:0]   partial;
    logic [ACCW-1:0]   accSum;

    mul_full_2bit u_mul (
        .a_i (digitA),
        .b_i (digitB),
        .p_o (p4)
    );

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign P         = p_q;

    // The weight of digit pair (i, j) is 4^(i+j). The shift amount is
    // therefore 2*(i+j), and it is formed by appending a zero bit. The digit
    // sum is one bit wider than the counters, so the highest pair does not wrap.
    always_comb begin
        digitSum = {1'b0, i_q} + {1'b0, j_q};
        partial  = ACCW'(p4) << {digitSum, 1'b0};
        accSum   = acc_q + partial;
    end

    // Next-state logic. By default every register holds its value.
    // The submodule sees zero digits outside RUN.
    // The final product is copied into p_q on the last RUN edge, so P changes
    // only when a new result is ready and stays put after the handshake.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        p_d     = p_q;
        i_d     = i_q;
        j_d     = j_q;
        digitA  = 2'b00;
        digitB  = 2'b00;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = RUN;
                    a_d     = A;
                    b_d     = B;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                end
            end

            RUN: begin
                digitA = 2'(a_q >> {i_q, 1'b0});
                digitB = 2'(b_q >> {j_q, 1'b0});
                acc_d  = accSum;
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        i_d     = '0;
                        p_d     = accSum;
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset overrides everything and drops any product that
    // is still in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

endmodule
